stat_monitor: RTL and testbench
===============================

Name: stat_monitor

Overview:
Producer side of the front-panel LED display path. Counts CPU execution statistics and debounces the 3-bit selector switches. Drives the selected statistic as a registered display word to the LED/display block. Sits between the CPU core's retire signals and the board display logic.

Parameters:
CNT_W, 16, width of every statistic counter and of disp_val (min 12)
DEB_CYCLES, 16, stable clk cycles required before a selector change is accepted (min 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
run  input  1  CPU running (not halted); gates all counting
instr_valid  input  1  one-cycle strobe: one instruction retired this cycle
pc_in  input  12  PC of the retiring instruction, sampled on instr_valid
branch_cond  input  1  retiring instruction is a conditional branch (qualified by instr_valid)
branch_taken  input  1  conditional branch taken (qualified by instr_valid & branch_cond)
jump_uncond  input  1  retiring instruction is an unconditional jump (qualified by instr_valid)
clr  input  1  synchronous clear of all counters and overflow flags
snap  input  1  snapshot strobe (used only with the optional feature)
sel_sw  input  3  raw, asynchronous selector switches
disp_val  output  CNT_W  registered display word
sel_q  output  3  debounced selector currently in effect
ovf  output  5  sticky saturation flags {jmp, taken, cond, instret, cycle}

Behaviour:
- Reset (reset=0, async): all counters, pc_reg, ovf, sel_q, disp_val and debounce state = 0. The synchronizer flops are also cleared.
- Counters: cycle_cnt, instret_cnt, cond_cnt, taken_cnt, jmp_cnt, each CNT_W bits. They advance only when run=1:
  - cycle_cnt: +1 every clk.
  - instret_cnt: +1 on instr_valid.
  - cond_cnt: +1 on instr_valid & branch_cond.
  - taken_cnt: +1 on instr_valid & branch_cond & branch_taken.
  - jmp_cnt: +1 on instr_valid & jump_uncond.
- branch_taken without branch_cond is ignored. branch_cond and jump_uncond both high counts both.
- Saturation: a counter at all-ones holds its value. Its ovf bit sets on the first increment attempt while saturated, and stays set until clr or reset.
- pc_reg: loads pc_in on instr_valid & run. It holds otherwise.
- clr=1: on the next edge, all counters, pc_reg and ovf = 0. clr wins over a simultaneous increment. sel_q and the debounce logic are unaffected.
- Selector path:
  - sel_sw passes through a 2-flop synchronizer to give sel_s.
  - A debounce counter resets to 0 whenever sel_s != sel_cand. At that point sel_cand loads sel_s.
  - Otherwise the counter increments, saturating at DEB_CYCLES-1.
  - When the counter reaches DEB_CYCLES-1 and sel_cand != sel_q, sel_q loads sel_cand.
  - Latency from a clean switch change to sel_q update = 2 + DEB_CYCLES cycles.
  - Glitches shorter than DEB_CYCLES never reach sel_q.
- Display mux, registered: disp_val updates every clk from the current sel_q and current counter values. It lags the source by 1 cycle.
  - 000 -> 0
  - 001 -> pc_reg, zero-extended
  - 010 -> cycle_cnt
  - 011 -> cond_cnt
  - 100 -> taken_cnt
  - 101 -> jmp_cnt
  - 110 -> instret_cnt
  - 111 -> ovf, zero-extended
- Reset mid-operation: immediate clear. Counting resumes on the first edge after release with run=1.
- run=0 freezes the counters and pc_reg. The display and debounce logic keep operating.

Optional Feature:
STAT_SNAPSHOT_EN
- Defined: a shadow register bank holds copies of the 5 counters, pc_reg and ovf.
  - snap=1 copies the post-update live values into the shadow bank on that edge. clr also clears the shadow bank.
  - disp_val selects from the shadow bank, so the panel shows a stable frame while the CPU runs.
  - Reset clears the shadow bank.
- Not defined: no shadow bank is built, snap is ignored, and disp_val shows live values.

Test Plan:
- Reset, then run=1 for 100 cycles, sel_sw=010 held since reset -> after debounce, disp_val=100 (±1 for register lag). All other counters = 0.
- run=1; 10 instr_valid pulses: 4 with branch_cond (3 taken), 2 with jump_uncond, pc_in last=0x3A5 -> cond=4, taken=3, jmp=2, instret=10; sel 001 shows 0x03A5.
- sel_sw toggles 011->100 for 5 cycles then back (DEB_CYCLES=16) -> sel_q stays 011. A steady 100 updates sel_q exactly 18 cycles after the change.
- CNT_W=12, run=1 for 4100 cycles -> cycle_cnt=0xFFF, ovf[0]=1. Then clr=1 together with instr_valid -> all counters 0, ovf=0.
- Assert reset=0 asynchronously mid-count (not on a clk edge) -> disp_val, sel_q and ovf go to 0 immediately. run=0 with instr_valid pulses -> no counter change.
- With STAT_SNAPSHOT_EN: snap at cycle_cnt=50, run continues 30 cycles, sel=010 -> disp_val stays 50. A second snap shows 80+.

Source files
------------

// File: rtl/stat_monitor.sv
// stat_monitor: CPU execution statistics counters with debounced display selector.
// Optional STAT_SNAPSHOT_EN builds a shadow bank so the panel shows a frozen frame.
module stat_monitor #(
    parameter int CNT_W      = 16,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             instr_valid,
    input  logic [11:0]      pc_in,
    input  logic             branch_cond,
    input  logic             branch_taken,
    input  logic             jump_uncond,
    input  logic             clr,
    input  logic             snap,
    input  logic [2:0]       sel_sw,
    output logic [CNT_W-1:0] disp_val,
    output logic [2:0]       sel_q,
    output logic [4:0]       ovf
);

    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0]    DEB_MAX = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0]    DEB_PRE = DW'(DEB_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // counter index order matches ovf: {jmp, taken, cond, instret, cycle}
    logic [4:0][CNT_W-1:0] r_cnt;
    logic [4:0][CNT_W-1:0] w_cnt_nxt;
    logic [11:0]           r_pc;
    logic [11:0]           w_pc_nxt;
    logic [4:0]            r_ovf;
    logic [4:0]            w_ovf_nxt;
    logic [4:0]            w_inc;

    logic [2:0]            r_sync1;
    logic [2:0]            r_sync2;
    logic [2:0]            r_cand;
    logic [DW-1:0]         r_deb;
    logic [2:0]            r_sel_q;

    logic [CNT_W-1:0]      r_disp;
    logic [CNT_W-1:0]      w_disp_nxt;

    logic [4:0][CNT_W-1:0] w_src_cnt;
    logic [11:0]           w_src_pc;
    logic [4:0]            w_src_ovf;

    assign w_inc = {5{run}} & {
        instr_valid & jump_uncond,
        instr_valid & branch_cond & branch_taken,
        instr_valid & branch_cond,
        instr_valid,
        1'b1
    };

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        w_pc_nxt  = r_pc;
        if (clr) begin
            w_cnt_nxt = '0;
            w_ovf_nxt = '0;
            w_pc_nxt  = '0;
        end else begin
            if (run && instr_valid) begin
                w_pc_nxt = pc_in;
            end
            for (int i = 0; i < 5; i++) begin
                if (w_inc[i]) begin
                    if (&r_cnt[i]) begin
                        w_ovf_nxt[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_ovf <= '0;
            r_pc  <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            r_pc  <= w_pc_nxt;
        end
    end

    // sel_q moves on the same edge the counter reaches DEB_CYCLES-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_deb   <= '0;
            r_sel_q <= '0;
        end else begin
            r_sync1 <= sel_sw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_deb  <= '0;
            end else begin
                if (r_deb != DEB_MAX) begin
                    r_deb <= r_deb + DW'(1);
                end
                if (r_deb >= DEB_PRE && r_cand != r_sel_q) begin
                    r_sel_q <= r_cand;
                end
            end
        end
    end

`ifdef STAT_SNAPSHOT_EN
    logic [4:0][CNT_W-1:0] r_sh_cnt;
    logic [11:0]           r_sh_pc;
    logic [4:0]            r_sh_ovf;

    // next-state values are already zero under clr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh_cnt <= '0;
            r_sh_pc  <= '0;
            r_sh_ovf <= '0;
        end else if (clr || snap) begin
            r_sh_cnt <= w_cnt_nxt;
            r_sh_pc  <= w_pc_nxt;
            r_sh_ovf <= w_ovf_nxt;
        end
    end

    assign w_src_cnt = r_sh_cnt;
    assign w_src_pc  = r_sh_pc;
    assign w_src_ovf = r_sh_ovf;
`else
    logic w_unused_snap;

    assign w_unused_snap = snap;
    assign w_src_cnt     = r_cnt;
    assign w_src_pc      = r_pc;
    assign w_src_ovf     = r_ovf;
`endif

    always_comb begin
        w_disp_nxt = '0;
        unique case (r_sel_q)
            3'b000: w_disp_nxt = '0;
            3'b001: w_disp_nxt = CNT_W'(w_src_pc);
            3'b010: w_disp_nxt = w_src_cnt[0];
            3'b011: w_disp_nxt = w_src_cnt[2];
            3'b100: w_disp_nxt = w_src_cnt[3];
            3'b101: w_disp_nxt = w_src_cnt[4];
            3'b110: w_disp_nxt = w_src_cnt[1];
            3'b111: w_disp_nxt = CNT_W'(w_src_ovf);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_disp <= '0;
        end else begin
            r_disp <= w_disp_nxt;
        end
    end

    assign disp_val = r_disp;
    assign sel_q    = r_sel_q;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_stat_monitor.sv
// tb_stat_monitor: directed scoreboard bench for stat_monitor
// (CNT_W=12, DEB_CYCLES=16, default build).
module tb_stat_monitor;

    localparam int CW  = 12;
    localparam int DEB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          instr_valid;
    logic [11:0]   pc_in;
    logic          branch_cond;
    logic          branch_taken;
    logic          jump_uncond;
    logic          clr;
    logic          snap;
    logic [2:0]    sel_sw;
    logic [CW-1:0] disp_val;
    logic [2:0]    sel_q;
    logic [4:0]    ovf;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [11:0] val;
    } exp_t;

    exp_t sb[$];

    stat_monitor #(
        .CNT_W(CW),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .instr_valid(instr_valid),
        .pc_in(pc_in),
        .branch_cond(branch_cond),
        .branch_taken(branch_taken),
        .jump_uncond(jump_uncond),
        .clr(clr),
        .snap(snap),
        .sel_sw(sel_sw),
        .disp_val(disp_val),
        .sel_q(sel_q),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [11:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [11:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s observed=%h expected=%h",
                       e.tag, obs, e.val);
            end
        end
    endtask

    // 18 edges for sel_q to follow, one more for disp_val
    task automatic select(input logic [2:0] v);
        sel_sw = v;
        repeat (DEB + 3) tick();
    endtask

    initial begin
        reset        = 1'b0;
        run          = 1'b0;
        instr_valid  = 1'b0;
        pc_in        = '0;
        branch_cond  = 1'b0;
        branch_taken = 1'b0;
        jump_uncond  = 1'b0;
        clr          = 1'b0;
        snap         = 1'b0;
        sel_sw       = 3'b010;
        repeat (3) tick();
        push("rst_disp", 12'h000);
        pop_check(disp_val);
        push("rst_sel", 12'h000);
        pop_check({9'b0, sel_q});
        push("rst_ovf", 12'h000);
        pop_check({7'b0, ovf});

        // 100 running cycles, selector 010 held since reset
        reset = 1'b1;
        run   = 1'b1;
        repeat (100) tick();
        push("sel_after_deb", 12'h002);
        pop_check({9'b0, sel_q});
        push("cycle_100_lag", 12'd99);
        pop_check(disp_val);
        run = 1'b0;
        tick();
        push("cycle_frozen", 12'd100);
        pop_check(disp_val);

        // 10 retirements: 4 cond (3 taken), 2 jumps, one stray taken
        run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instr_valid  = 1'b1;
            pc_in        = (i == 9) ? 12'h3A5 : 12'h100 + 12'(i);
            branch_cond  = (i < 4);
            branch_taken = (i < 3) || (i == 6);
            jump_uncond  = (i == 3) || (i == 4);
            tick();
        end
        instr_valid  = 1'b0;
        branch_cond  = 1'b0;
        branch_taken = 1'b0;
        jump_uncond  = 1'b0;
        run          = 1'b0;
        select(3'b001);
        push("pc_reg", 12'h3A5);
        pop_check(disp_val);
        select(3'b110);
        push("instret", 12'd10);
        pop_check(disp_val);
        select(3'b101);
        push("jmp", 12'd2);
        pop_check(disp_val);
        select(3'b011);
        push("cond", 12'd4);
        pop_check(disp_val);

        // 5-cycle glitch to 100 must not reach sel_q
        sel_sw = 3'b100;
        repeat (5) tick();
        sel_sw = 3'b011;
        repeat (25) tick();
        push("glitch_sel", 12'h003);
        pop_check({9'b0, sel_q});

        // steady change: exactly 18 edges
        sel_sw = 3'b100;
        repeat (17) tick();
        push("sel_edge17", 12'h003);
        pop_check({9'b0, sel_q});
        tick();
        push("sel_edge18", 12'h004);
        pop_check({9'b0, sel_q});
        tick();
        push("taken", 12'd3);
        pop_check(disp_val);

        // run=0 freezes counters and pc_reg
        select(3'b110);
        instr_valid = 1'b1;
        branch_cond = 1'b1;
        jump_uncond = 1'b1;
        pc_in       = 12'h7FF;
        repeat (3) tick();
        instr_valid = 1'b0;
        branch_cond = 1'b0;
        jump_uncond = 1'b0;
        tick();
        push("frz_instret", 12'd10);
        pop_check(disp_val);
        select(3'b001);
        push("frz_pc", 12'h3A5);
        pop_check(disp_val);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        push("clr_pc", 12'h000);
        pop_check(disp_val);

        // saturation of cycle_cnt
        select(3'b010);
        push("clr_cycle", 12'h000);
        pop_check(disp_val);
        run = 1'b1;
        repeat (4100) tick();
        push("sat_cycle", 12'hFFF);
        pop_check(disp_val);
        select(3'b111);
        push("ovf_disp", 12'h001);
        pop_check(disp_val);
        push("ovf_port", 12'h001);
        pop_check({7'b0, ovf});

        // clr beats a simultaneous retirement
        clr         = 1'b1;
        instr_valid = 1'b1;
        tick();
        clr         = 1'b0;
        instr_valid = 1'b0;
        run         = 1'b0;
        tick();
        push("ovf_clr_disp", 12'h000);
        pop_check(disp_val);
        push("ovf_clr_port", 12'h000);
        pop_check({7'b0, ovf});
        select(3'b110);
        push("clr_instret", 12'h000);
        pop_check(disp_val);

        // asynchronous reset between edges
        select(3'b010);
        run = 1'b1;
        repeat (20) tick();
        #3;
        reset = 1'b0;
        #1;
        push("arst_disp", 12'h000);
        pop_check(disp_val);
        push("arst_sel", 12'h000);
        pop_check({9'b0, sel_q});
        push("arst_ovf", 12'h000);
        pop_check({7'b0, ovf});
        reset = 1'b1;
        repeat (30) tick();
        push("resume_cycle", 12'd29);
        pop_check(disp_val);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
